// File: rtl/fsb8_pkg.sv
// fsb8_pkg: shared FSM encoding, burst default and bridge frame-state constants
// for the two-master FSB8 arbiter.
package fsb8_pkg;
    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;
    localparam int MAX_BURST_DEF = 256;
    typedef enum logic [1:0] {
        FRM_STANDBY = 2'd0,
        FRM_CMD     = 2'd1,
        FRM_DATA    = 2'd2,
        FRM_TURN    = 2'd3
    } frame_t;
endpackage

// File: rtl/fsb8_arb_rr.sv
// rr_pick2: two-way round-robin pick; on a tie the requester that did not own
// the bus last wins.
module rr_pick2
    import fsb8_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick
);
    assign pick = &req ? ~last : req[1];
endmodule

// File: rtl/fsb8_arb.sv
// fsb8_arb: two-requester arbiter in front of an 8-bit FSB bridge; the owner is
// mirrored straight through, bursts are capped at MAX_BURST beats.
module fsb8_arb
    import fsb8_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int MAX_BURST  = MAX_BURST_DEF
) (
    input  logic                  hclk,
    input  logic                  hreset_n,
    input  logic                  m0_hsel,
    input  logic                  m0_hsel_cmd,
    input  logic                  m0_htrans,
    input  logic                  m0_hburst,
    input  logic                  m0_hwrite,
    input  logic [ADDR_WIDTH-1:0] m0_haddr,
    input  logic [7:0]            m0_hwdata,
    output logic [7:0]            m0_hrdata,
    output logic                  m0_hready,
    input  logic                  m1_hsel,
    input  logic                  m1_hsel_cmd,
    input  logic                  m1_htrans,
    input  logic                  m1_hburst,
    input  logic                  m1_hwrite,
    input  logic [ADDR_WIDTH-1:0] m1_haddr,
    input  logic [7:0]            m1_hwdata,
    output logic [7:0]            m1_hrdata,
    output logic                  m1_hready,
    output logic                  hsel,
    output logic                  hsel_cmd,
    output logic                  htrans,
    output logic                  hburst,
    output logic                  hwrite,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [7:0]            hwdata,
    input  logic [7:0]            hrdata,
    input  logic                  hready,
    output logic [1:0]            grant,
    output logic                  busy
);
    localparam logic [7:0] BEAT_CAP = 8'(MAX_BURST - 1);

    state_t          r_state, w_state_nxt;
    logic            r_owner, w_owner_nxt;
    logic            r_last, w_last_nxt;
    logic [7:0]      r_beat, w_beat_nxt;
    logic            w_req0, w_req1, w_pick, w_own, w_own0, w_own1;
    logic            w_o_req, w_o_hburst, w_cap, w_done, w_release;

    assign w_req0     = (m0_hsel | m0_hsel_cmd) & m0_htrans;
    assign w_req1     = (m1_hsel | m1_hsel_cmd) & m1_htrans;
    assign w_own      = r_state == OWN;
    assign w_own0     = w_own & ~r_owner;
    assign w_own1     = w_own & r_owner;
    assign w_o_req    = r_owner ? w_req1 : w_req0;
    assign w_o_hburst = r_owner ? m1_hburst : m0_hburst;
    assign w_cap      = r_beat == BEAT_CAP;
    assign w_done     = w_own & hready;
    // An owner that drops its request gives the bus up without a final beat.
    assign w_release  = w_own & (~w_o_req | (w_done & (~w_o_hburst | w_cap)));

    rr_pick2 u_rr (
        .req  ({w_req1, w_req0}),
        .last (r_last),
        .pick (w_pick)
    );

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_beat  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_beat_nxt  = r_beat;
        if (!w_own) begin
            if (w_req0 | w_req1) begin
                w_state_nxt = OWN;
                w_owner_nxt = w_pick;
                w_beat_nxt  = 8'd0;
            end
        end else if (w_release) begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_owner;
            w_beat_nxt  = 8'd0;
        end else if (w_done) begin
            w_beat_nxt  = r_beat + 8'd1;
        end
    end

    assign hsel      = w_own0 ? m0_hsel     : w_own1 & m1_hsel;
    assign hsel_cmd  = w_own0 ? m0_hsel_cmd : w_own1 & m1_hsel_cmd;
    assign htrans    = w_own0 ? m0_htrans   : w_own1 & m1_htrans;
    assign hwrite    = w_own0 ? m0_hwrite   : w_own1 & m1_hwrite;
    assign hburst    = w_own & w_o_hburst & ~w_cap;
    assign haddr     = w_own0 ? m0_haddr  : (w_own1 ? m1_haddr  : '0);
    assign hwdata    = w_own0 ? m0_hwdata : (w_own1 ? m1_hwdata : 8'h00);
    assign m0_hrdata = w_own0 ? hrdata : 8'h00;
    assign m1_hrdata = w_own1 ? hrdata : 8'h00;
    // Reset forces both requesters to see a ready bus.
    assign m0_hready = ~hreset_n | (w_own0 ? hready : ~w_req0);
    assign m1_hready = ~hreset_n | (w_own1 ? hready : ~w_req1);
    assign grant     = {w_own1, w_own0};
    assign busy      = w_own;
endmodule

// File: tb/tb_fsb8_arb.sv
// tb_fsb8_arb: cycle table plus hand sequences for fsb8_arb with MAX_BURST=4;
// delivered beats are matched against a scoreboard queue.
module tb_fsb8_arb;
    localparam logic [23:0] A0 = 24'h000100, A1 = 24'h020200;
    localparam logic [7:0]  W0 = 8'hA0, W1 = 8'hB1;

    typedef struct packed {
        logic r0, r1, b0, b1, rdy;
        logic [7:0] d;
        logic [1:0] g;
        logic fb, h0, h1;
        logic [1:0] dst;
    } vec_t;
    typedef struct packed {
        logic id;
        logic [7:0] d;
    } sb_t;

    logic hclk = 1'b0, hreset_n = 1'b0;
    logic m0_hsel, m0_hsel_cmd, m0_htrans, m0_hburst, m0_hwrite, m0_hready;
    logic m1_hsel, m1_hsel_cmd, m1_htrans, m1_hburst, m1_hwrite, m1_hready;
    logic [23:0] m0_haddr, m1_haddr, haddr;
    logic [7:0] m0_hwdata, m1_hwdata, m0_hrdata, m1_hrdata, hwdata, hrdata;
    logic hsel, hsel_cmd, htrans, hburst, hwrite, hready, busy;
    logic [1:0] grant;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   checks = 0, failures = 0;

    always #5 hclk = ~hclk;

    fsb8_arb #(.ADDR_WIDTH(24), .MAX_BURST(4)) dut (
        .hclk(hclk), .hreset_n(hreset_n),
        .m0_hsel(m0_hsel), .m0_hsel_cmd(m0_hsel_cmd), .m0_htrans(m0_htrans),
        .m0_hburst(m0_hburst), .m0_hwrite(m0_hwrite), .m0_haddr(m0_haddr),
        .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata), .m0_hready(m0_hready),
        .m1_hsel(m1_hsel), .m1_hsel_cmd(m1_hsel_cmd), .m1_htrans(m1_htrans),
        .m1_hburst(m1_hburst), .m1_hwrite(m1_hwrite), .m1_haddr(m1_haddr),
        .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata), .m1_hready(m1_hready),
        .hsel(hsel), .hsel_cmd(hsel_cmd), .htrans(htrans), .hburst(hburst),
        .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .grant(grant), .busy(busy)
    );

    function automatic vec_t mk(input logic r0, r1, b0, b1, rdy, input logic [7:0] d,
                                input logic [1:0] g, input logic fb, h0, h1,
                                input logic [1:0] dst);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.b0 = b0; v.b1 = b1; v.rdy = rdy; v.d = d;
        v.g = g; v.fb = fb; v.h0 = h0; v.h1 = h1; v.dst = dst;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        sb_t e;
        m0_hsel = v.r0; m0_htrans = v.r0; m0_hburst = v.b0;
        m1_hsel_cmd = v.r1; m1_htrans = v.r1; m1_hburst = v.b1;
        hready = v.rdy; hrdata = v.d;
        if (v.dst != 2'd0) begin
            e.id = v.dst == 2'd2;
            e.d = v.d;
            sbq.push_back(e);
        end
    endtask

    task automatic check_row(input vec_t v, input int i);
        string t;
        t = $sformatf("row%0d", i);
        chk({t, "_grant"}, 32'(grant), 32'(v.g));
        chk({t, "_busy"}, 32'(busy), 32'(v.g != 2'b00));
        chk({t, "_hsel"}, 32'(hsel), 32'(v.g == 2'b01 && v.r0));
        chk({t, "_hsel_cmd"}, 32'(hsel_cmd), 32'(v.g == 2'b10 && v.r1));
        chk({t, "_htrans"}, 32'(htrans), 32'(v.g == 2'b01 ? v.r0 : (v.g == 2'b10 ? v.r1 : 1'b0)));
        chk({t, "_hburst"}, 32'(hburst), 32'(v.fb));
        chk({t, "_hwrite"}, 32'(hwrite), 32'(v.g == 2'b01));
        chk({t, "_haddr"}, 32'(haddr), 32'(v.g == 2'b01 ? A0 : (v.g == 2'b10 ? A1 : 24'h0)));
        chk({t, "_hwdata"}, 32'(hwdata), 32'(v.g == 2'b01 ? W0 : (v.g == 2'b10 ? W1 : 8'h0)));
        chk({t, "_m0_hready"}, 32'(m0_hready), 32'(v.h0));
        chk({t, "_m1_hready"}, 32'(m1_hready), 32'(v.h1));
        if (v.g != 2'b01) chk({t, "_m0_hrdata"}, 32'(m0_hrdata), 32'h0);
        if (v.g != 2'b10) chk({t, "_m1_hrdata"}, 32'(m1_hrdata), 32'h0);
    endtask

    task automatic deliver(input logic id, input logic [7:0] d);
        sb_t e;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_extra: m%0d got beat %02h, expected none", id, d);
        end else begin
            e = sbq.pop_front();
            chk("sb_id", 32'(id), 32'(e.id));
            chk("sb_data", 32'(d), 32'(e.d));
        end
    endtask

    always @(negedge hclk) begin
        if (hreset_n && m0_hready && m0_hsel && m0_htrans) deliver(1'b0, m0_hrdata);
        if (hreset_n && m1_hready && m1_hsel_cmd && m1_htrans) deliver(1'b1, m1_hrdata);
    end

    initial begin
        vec_t idle_v;
        idle_v = mk(0,0,0,0,1,8'h00,2'b00,0,1,1,0);
        m0_hsel_cmd = 1'b0; m1_hsel = 1'b0; m0_hwrite = 1'b1; m1_hwrite = 1'b0;
        m0_haddr = A0; m1_haddr = A1; m0_hwdata = W0; m1_hwdata = W1;
        apply(mk(1,1,1,1,1,8'hFF,2'b00,0,1,1,0));
        #2;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_hsel", 32'(hsel), 32'h0);
        chk("rst_hburst", 32'(hburst), 32'h0);
        chk("rst_haddr", 32'(haddr), 32'h0);
        chk("rst_m0_hready", 32'(m0_hready), 32'h1);
        chk("rst_m1_hready", 32'(m1_hready), 32'h1);
        chk("rst_m0_hrdata", 32'(m0_hrdata), 32'h0);
        chk("rst_m1_hrdata", 32'(m1_hrdata), 32'h0);
        @(posedge hclk); #1;
        hreset_n = 1'b1;
        apply(idle_v);
        // r0 r1 b0 b1 rdy data g fb h0 h1 dst
        tbl.push_back(mk(1,1,0,0,1,8'h00,2'b00,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,1,8'h11,2'b01,0,1,0,1));
        tbl.push_back(mk(0,1,0,0,1,8'h00,2'b00,0,1,0,0));
        tbl.push_back(mk(0,1,0,0,1,8'h22,2'b10,0,1,1,2));
        tbl.push_back(mk(0,0,0,0,1,8'h00,2'b00,0,1,1,0));
        tbl.push_back(mk(1,0,0,0,1,8'h00,2'b00,0,0,1,0));
        tbl.push_back(mk(1,0,0,0,1,8'h5A,2'b01,0,1,1,1));
        tbl.push_back(mk(0,0,0,0,1,8'h00,2'b00,0,1,1,0));
        tbl.push_back(mk(0,1,0,1,1,8'h00,2'b00,0,1,0,0));
        tbl.push_back(mk(0,1,0,1,1,8'h31,2'b10,1,1,1,2));
        tbl.push_back(mk(0,1,0,1,0,8'h00,2'b10,1,1,0,0));
        tbl.push_back(mk(1,1,0,1,1,8'h32,2'b10,1,0,1,2));
        tbl.push_back(mk(1,1,0,1,1,8'h33,2'b10,1,0,1,2));
        tbl.push_back(mk(1,1,0,0,1,8'h34,2'b10,0,0,1,2));
        tbl.push_back(mk(1,0,0,0,1,8'h00,2'b00,0,0,1,0));
        tbl.push_back(mk(1,0,0,0,1,8'h40,2'b01,0,1,1,1));
        tbl.push_back(mk(0,0,0,0,1,8'h00,2'b00,0,1,1,0));
        tbl.push_back(mk(1,0,1,0,1,8'h00,2'b00,0,0,1,0));
        tbl.push_back(mk(1,0,1,0,1,8'h51,2'b01,1,1,1,1));
        tbl.push_back(mk(1,0,1,0,1,8'h52,2'b01,1,1,1,1));
        tbl.push_back(mk(1,0,1,0,1,8'h53,2'b01,1,1,1,1));
        tbl.push_back(mk(1,0,1,0,1,8'h54,2'b01,0,1,1,1));
        tbl.push_back(mk(1,0,1,0,1,8'h00,2'b00,0,0,1,0));
        tbl.push_back(mk(1,1,1,0,1,8'h55,2'b01,1,1,0,1));
        tbl.push_back(mk(1,1,1,0,1,8'h56,2'b01,1,1,0,1));
        tbl.push_back(mk(1,1,1,0,1,8'h57,2'b01,1,1,0,1));
        tbl.push_back(mk(1,1,1,0,1,8'h58,2'b01,0,1,0,1));
        tbl.push_back(mk(1,1,1,0,1,8'h00,2'b00,0,0,0,0));
        tbl.push_back(mk(1,1,1,0,1,8'h61,2'b10,0,0,1,2));
        tbl.push_back(mk(1,0,1,0,1,8'h00,2'b00,0,0,1,0));
        tbl.push_back(mk(1,0,1,0,1,8'h59,2'b01,1,1,1,1));
        tbl.push_back(mk(1,0,0,0,1,8'h5B,2'b01,0,1,1,1));
        tbl.push_back(mk(0,0,0,0,1,8'h00,2'b00,0,1,1,0));
        tbl.push_back(mk(1,0,1,0,1,8'h00,2'b00,0,0,1,0));
        tbl.push_back(mk(1,0,1,0,1,8'h71,2'b01,1,1,1,1));
        tbl.push_back(mk(0,0,1,0,0,8'h00,2'b01,1,0,1,0));
        tbl.push_back(mk(0,0,0,0,1,8'h00,2'b00,0,1,1,0));
        foreach (tbl[i]) begin
            @(posedge hclk); #1;
            apply(tbl[i]);
            @(negedge hclk);
            check_row(tbl[i], i);
        end
        @(posedge hclk); #1;
        apply(mk(1,0,1,0,1,8'h00,2'b00,0,0,1,0));
        @(posedge hclk); #1;
        apply(mk(1,0,1,0,1,8'h81,2'b01,1,1,1,1));
        @(negedge hclk);
        chk("mr_grant_b1", 32'(grant), 32'h1);
        @(posedge hclk); #1;
        apply(mk(1,0,1,0,1,8'h82,2'b01,1,1,1,1));
        @(posedge hclk); #1;
        apply(mk(1,1,1,0,1,8'h83,2'b01,0,1,0,0));
        chk("mr_grant_b3", 32'(grant), 32'h1);
        #1 hreset_n = 1'b0;
        #1;
        chk("mr_grant", 32'(grant), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_hsel", 32'(hsel), 32'h0);
        chk("mr_htrans", 32'(htrans), 32'h0);
        chk("mr_hburst", 32'(hburst), 32'h0);
        chk("mr_haddr", 32'(haddr), 32'h0);
        chk("mr_m0_hready", 32'(m0_hready), 32'h1);
        chk("mr_m1_hready", 32'(m1_hready), 32'h1);
        chk("mr_m0_hrdata", 32'(m0_hrdata), 32'h0);
        @(posedge hclk); #1;
        hreset_n = 1'b1;
        @(negedge hclk);
        chk("mr_idle_grant", 32'(grant), 32'h0);
        chk("mr_idle_m0_hready", 32'(m0_hready), 32'h0);
        @(posedge hclk); #1;
        apply(mk(1,1,0,0,1,8'h90,2'b01,0,1,0,1));
        @(negedge hclk);
        chk("mr_tie_grant", 32'(grant), 32'h1);
        chk("mr_tie_m1_hready", 32'(m1_hready), 32'h0);
        @(posedge hclk); #1;
        apply(idle_v);
        @(negedge hclk);
        chk("end_grant", 32'(grant), 32'h0);
        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
